// File: rtl/rs232_sched_pkg.sv
// Shared types and helpers for the quick_rs232 transmit scheduler.
package rs232_sched_pkg;

   localparam int BYTE_W  = 8;
   localparam int MAX_REQ = 8;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD      = 2'd1,
      ST_WAIT_COPY = 2'd2,
      ST_DRAIN     = 2'd3
   } sched_state_e;

   // One-hot decode of a requester index; callers keep the low NUM_REQ bits.
   function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
      logic [MAX_REQ-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rs232_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last_grant+1 with wrap.
module rs232_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int LG_W    = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [LG_W-1:0]    i_last_grant,
   output logic [NUM_REQ-1:0] o_winner,
   output logic               o_valid
);

   logic [LG_W:0]          w_start;
   logic [2*NUM_REQ-1:0]   w_dbl;
   logic [NUM_REQ-1:0]     w_rot;
   logic [NUM_REQ-1:0]     w_pick;
   logic [2*NUM_REQ-1:0]   w_pick_dbl;

   // Rotate so bit 0 is the highest-priority requester, take the lowest set
   // bit, then rotate the pick back into absolute position.
   assign w_start    = {1'b0, i_last_grant} + {{LG_W{1'b0}}, 1'b1};
   assign w_dbl      = {i_req, i_req};
   assign w_rot      = NUM_REQ'(w_dbl >> w_start);
   assign w_pick     = w_rot & (~w_rot + {{(NUM_REQ-1){1'b0}}, 1'b1});
   assign w_pick_dbl = {w_pick, w_pick};
   assign o_winner   = NUM_REQ'((w_pick_dbl << w_start) >> NUM_REQ);
   assign o_valid    = |i_req;

endmodule

// File: rtl/rs232_tx_scheduler.sv
// Round-robin packet scheduler sharing one quick_rs232 transmitter between
// NUM_REQ byte-stream requesters, with burst limit, stall and copy watchdogs.
module rs232_tx_scheduler
   import rs232_sched_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int MAX_BURST    = 16,
   parameter int IDLE_TIMEOUT = 1024,
   parameter int COPY_TIMEOUT = 65536
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [NUM_REQ-1:0]        i_req_valid,
   input  logic [BYTE_W*NUM_REQ-1:0] i_req_data,
   input  logic [NUM_REQ-1:0]        i_req_last,
   output logic [NUM_REQ-1:0]        o_req_ready,
   output logic [NUM_REQ-1:0]        o_grant,
   output logic                      o_tx_transaction,
   output logic [BYTE_W-1:0]         o_tx_data,
   output logic                      o_tx_data_ready,
   input  logic                      i_tx_data_copied,
   input  logic                      i_tx_busy,
   output logic                      o_sched_busy,
   output logic                      o_err_stall,
   output logic                      o_err_copy
);

   localparam int LG_W   = $clog2(NUM_REQ);
   localparam int IDLE_W = $clog2(IDLE_TIMEOUT);
   localparam int COPY_W = $clog2(COPY_TIMEOUT);
   localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);
   localparam logic [COPY_W-1:0] COPY_LAST  = COPY_W'(COPY_TIMEOUT - 1);
   localparam logic [7:0]        BURST_LAST = 8'(MAX_BURST - 1);

   sched_state_e        r_state, w_state_next;
   logic [NUM_REQ-1:0]  r_grant, w_grant_next;
   logic [LG_W-1:0]     r_last_grant, w_last_grant_next;
   logic                r_tx_trans, w_tx_trans_next;
   logic [BYTE_W-1:0]   r_tx_data, w_tx_data_next;
   logic                r_tx_rdy, w_tx_rdy_next;
   logic                r_last, w_last_next;
   logic [7:0]          r_byte_cnt, w_byte_cnt_next;
   logic [IDLE_W-1:0]   r_idle_cnt, w_idle_cnt_next;
   logic [COPY_W-1:0]   r_copy_cnt, w_copy_cnt_next;
   logic                r_busy_lo, w_busy_lo_next;
   logic                r_err_stall, w_err_stall_next;
   logic                r_err_copy, w_err_copy_next;

   logic [NUM_REQ-1:0]  w_winner;
   logic                w_arb_valid;
   logic [LG_W-1:0]     w_win_idx;
   logic [LG_W-1:0]     w_cur_idx;
   logic [BYTE_W-1:0]   w_masked [NUM_REQ];
   logic [BYTE_W-1:0]   w_sel_data;
   logic                w_sel_valid;
   logic                w_sel_last;

   rs232_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .LG_W    (LG_W)
   ) u_arb (
      .i_req        (i_req_valid),
      .i_last_grant (r_last_grant),
      .o_winner     (w_winner),
      .o_valid      (w_arb_valid)
   );

   // Per-requester byte masked by its grant bit; the OR below forms the mux.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
         assign w_masked[gi] = i_req_data[BYTE_W*gi +: BYTE_W] & {BYTE_W{r_grant[gi]}};
      end
   endgenerate

   // Owner's byte, plus one-hot to index conversion for winner and owner.
   always_comb begin
      w_sel_data = '0;
      w_win_idx  = '0;
      w_cur_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sel_data = w_sel_data | w_masked[k];
         if (w_winner[k]) w_win_idx = LG_W'(k);
         if (r_grant[k])  w_cur_idx = LG_W'(k);
      end
   end

   assign w_sel_valid = |(i_req_valid & r_grant);
   assign w_sel_last  = |(i_req_last & r_grant);

   // Next-state and next-register logic for the grant/handshake FSM.
   always_comb begin
      w_state_next      = r_state;
      w_grant_next      = r_grant;
      w_last_grant_next = r_last_grant;
      w_tx_trans_next   = r_tx_trans;
      w_tx_data_next    = r_tx_data;
      w_tx_rdy_next     = r_tx_rdy;
      w_last_next       = r_last;
      w_byte_cnt_next   = r_byte_cnt;
      w_idle_cnt_next   = r_idle_cnt;
      w_copy_cnt_next   = r_copy_cnt;
      w_busy_lo_next    = r_busy_lo;
      w_err_stall_next  = 1'b0;
      w_err_copy_next   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_arb_valid) begin
               w_grant_next    = NUM_REQ'(onehot(3'(w_win_idx)));
               w_tx_trans_next = 1'b1;
               w_byte_cnt_next = '0;
               w_idle_cnt_next = '0;
               w_state_next    = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (w_sel_valid) begin
               w_tx_data_next  = w_sel_data;
               w_last_next     = w_sel_last;
               w_tx_rdy_next   = 1'b1;
               w_copy_cnt_next = '0;
               w_idle_cnt_next = '0;
               w_state_next    = ST_WAIT_COPY;
            end else if (r_idle_cnt == IDLE_LAST) begin
               w_err_stall_next = 1'b1;
               w_busy_lo_next   = 1'b0;
               w_state_next     = ST_DRAIN;
            end else if (r_idle_cnt != '1) begin
               w_idle_cnt_next = r_idle_cnt + IDLE_W'(1);
            end
         end
         ST_WAIT_COPY: begin
            if (i_tx_data_copied) begin
               w_tx_rdy_next = 1'b0;
               if (r_byte_cnt != 8'hFF) w_byte_cnt_next = r_byte_cnt + 8'd1;
               if (r_last || (r_byte_cnt == BURST_LAST)) begin
                  w_busy_lo_next = 1'b0;
                  w_state_next   = ST_DRAIN;
               end else begin
                  w_state_next = ST_LOAD;
               end
            end else if (r_copy_cnt == COPY_LAST) begin
               w_err_copy_next = 1'b1;
               w_tx_rdy_next   = 1'b0;
               w_busy_lo_next  = 1'b0;
               w_state_next    = ST_DRAIN;
            end else if (r_copy_cnt != '1) begin
               w_copy_cnt_next = r_copy_cnt + COPY_W'(1);
            end
         end
         ST_DRAIN: begin
            // Two consecutive idle samples: the serializer may raise busy late.
            if (i_tx_busy) begin
               w_busy_lo_next = 1'b0;
            end else if (r_busy_lo) begin
               w_busy_lo_next    = 1'b0;
               w_tx_trans_next   = 1'b0;
               w_grant_next      = '0;
               w_last_grant_next = w_cur_idx;
               w_state_next      = ST_IDLE;
            end else begin
               w_busy_lo_next = 1'b1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any byte in flight.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_grant      <= '0;
         r_last_grant <= LG_W'(NUM_REQ - 1);
         r_tx_trans   <= 1'b0;
         r_tx_data    <= '0;
         r_tx_rdy     <= 1'b0;
         r_last       <= 1'b0;
         r_byte_cnt   <= '0;
         r_idle_cnt   <= '0;
         r_copy_cnt   <= '0;
         r_busy_lo    <= 1'b0;
         r_err_stall  <= 1'b0;
         r_err_copy   <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_grant      <= w_grant_next;
         r_last_grant <= w_last_grant_next;
         r_tx_trans   <= w_tx_trans_next;
         r_tx_data    <= w_tx_data_next;
         r_tx_rdy     <= w_tx_rdy_next;
         r_last       <= w_last_next;
         r_byte_cnt   <= w_byte_cnt_next;
         r_idle_cnt   <= w_idle_cnt_next;
         r_copy_cnt   <= w_copy_cnt_next;
         r_busy_lo    <= w_busy_lo_next;
         r_err_stall  <= w_err_stall_next;
         r_err_copy   <= w_err_copy_next;
      end
   end

   assign o_req_ready      = (r_state == ST_LOAD) ? (r_grant & i_req_valid) : '0;
   assign o_grant          = r_grant;
   assign o_tx_transaction = r_tx_trans;
   assign o_tx_data        = r_tx_data;
   assign o_tx_data_ready  = r_tx_rdy;
   assign o_sched_busy     = (r_state != ST_IDLE);
   assign o_err_stall      = r_err_stall;
   assign o_err_copy       = r_err_copy;

endmodule

// File: tb/tb_rs232_tx_scheduler.sv
// Directed bench: requester queues and a quick_rs232 stand-in drive the
// scheduler; a negedge monitor logs bytes, grants and protocol violations.
module tb_rs232_tx_scheduler;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0]   req_last = '0;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   grant;
   logic           tx_transaction;
   logic [7:0]     tx_data;
   logic           tx_data_ready;
   logic           tx_copied = 1'b0;
   logic           tx_busy = 1'b0;
   logic           sched_busy;
   logic           err_stall;
   logic           err_copy;

   rs232_tx_scheduler #(.NUM_REQ(N)) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_req_valid      (req_valid),
      .i_req_data       (req_data),
      .i_req_last       (req_last),
      .o_req_ready      (req_ready),
      .o_grant          (grant),
      .o_tx_transaction (tx_transaction),
      .o_tx_data        (tx_data),
      .o_tx_data_ready  (tx_data_ready),
      .i_tx_data_copied (tx_copied),
      .i_tx_busy        (tx_busy),
      .o_sched_busy     (sched_busy),
      .o_err_stall      (err_stall),
      .o_err_copy       (err_copy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // requester queues: {last, data}
   logic [8:0] qmem [N][64];
   int q_wr [N];
   int q_rd [N];
   logic [N-1:0] ready_s = '0;
   logic rdy_s = 1'b0;

   // transmitter stand-in
   bit copy_en = 1'b1;
   int rdy_cnt = 0;
   int busy_cnt = 0;

   // monitor logs
   logic [7:0] log_data [64];
   int log_req [64];
   int log_seq [64];
   int n_log = 0;
   int glog [64];
   int n_glog = 0;
   int rr_cnt [N];
   int n_stall = 0, n_copy = 0;
   int cyc_stall = 0, cyc_copy = 0, cyc_rdy_rise = 0, cyc_rdy_fall = 0;
   int n_holdoff = 0, n_unstable = 0, n_drain_bad = 0;
   logic [N-1:0] grant_prev = '0;
   logic rdy_prev = 1'b0, trans_prev = 1'b0, busy_h1 = 1'b0, busy_h2 = 1'b0;
   logic [7:0] data_prev = '0;

   function automatic int idx_of(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   always @(posedge clk) cyc++;

   // requester model: pop on a captured byte, present the queue head
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < N; i++) begin
         if (ready_s[i] && q_rd[i] < q_wr[i]) q_rd[i]++;
         if (q_rd[i] < q_wr[i]) begin
            req_valid[i]        = 1'b1;
            req_last[i]         = qmem[i][q_rd[i]][8];
            req_data[8*i +: 8]  = qmem[i][q_rd[i]][7:0];
         end else begin
            req_valid[i]        = 1'b0;
            req_last[i]         = 1'b0;
            req_data[8*i +: 8]  = 8'h00;
         end
      end
   end

   // transmitter model: copy 5 cycles after ready, then busy for 4 cycles
   always @(posedge clk) begin
      #1;
      tx_copied = 1'b0;
      if (busy_cnt > 0) busy_cnt--;
      if (rdy_s && copy_en && rst_n) begin
         rdy_cnt++;
         if (rdy_cnt == 5) begin
            tx_copied = 1'b1;
            rdy_cnt   = 0;
            busy_cnt  = 4;
         end
      end else begin
         rdy_cnt = 0;
      end
      tx_busy = (busy_cnt > 0);
   end

   // monitor
   always @(negedge clk) begin
      ready_s = req_ready;
      rdy_s   = tx_data_ready;
      for (int i = 0; i < N; i++) if (req_ready[i]) rr_cnt[i]++;
      if ((req_ready & ~grant) != '0) n_holdoff++;
      if (tx_data_ready && tx_copied && n_log < 64) begin
         log_data[n_log] = tx_data;
         log_req[n_log]  = idx_of(grant);
         log_seq[n_log]  = n_glog - 1;
         $display("[TB] byte 0x%02h from req %0d", tx_data, idx_of(grant));
         n_log++;
      end
      if (rdy_prev && tx_data_ready && tx_data != data_prev) n_unstable++;
      if (!rdy_prev && tx_data_ready) cyc_rdy_rise = cyc;
      if (rdy_prev && !tx_data_ready) cyc_rdy_fall = cyc;
      if (err_stall) begin n_stall++; cyc_stall = cyc; end
      if (err_copy)  begin n_copy++;  cyc_copy  = cyc; end
      if (grant != '0 && grant_prev == '0 && n_glog < 64) begin
         glog[n_glog] = idx_of(grant);
         n_glog++;
      end
      if (trans_prev && !tx_transaction && rst_n && (busy_h1 || busy_h2)) n_drain_bad++;
      busy_h2    = busy_h1;
      busy_h1    = tx_busy;
      grant_prev = grant;
      rdy_prev   = tx_data_ready;
      trans_prev = tx_transaction;
      data_prev  = tx_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
         $display("[TB] %s = 0x%0h ok", tag, obs);
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int r, input logic [7:0] d, input logic l);
      qmem[r][q_wr[r]] = {l, d};
      q_wr[r]++;
   endtask

   task automatic clear_logs();
      n_log = 0; n_glog = 0; n_stall = 0; n_copy = 0;
      for (int i = 0; i < N; i++) rr_cnt[i] = 0;
   endtask

   task automatic clear_queues();
      for (int i = 0; i < N; i++) begin q_wr[i] = 0; q_rd[i] = 0; end
   endtask

   function automatic bit queues_empty();
      for (int i = 0; i < N; i++) if (q_rd[i] < q_wr[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic run_quiet(input int budget, input string tag);
      int k;
      bit done;
      k = 0;
      done = 1'b0;
      while (!done && k < budget) begin
         @(posedge clk); #2;
         k++;
         done = queues_empty() && !sched_busy && !tx_busy;
      end
      chk(tag, 32'(done), 32'd1);
      repeat (2) @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      @(posedge clk); #3;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      clear_queues();
      rst_n = 1'b1;
   endtask

   initial begin
      int c0, c1;
      bit seen;
      clear_queues();
      clear_logs();

      // ---- reset state
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_grant",   32'(grant), 32'd0);
      chk("rst_trans",   32'(tx_transaction), 32'd0);
      chk("rst_rdy",     32'(tx_data_ready), 32'd0);
      chk("rst_data",    32'(tx_data), 32'd0);
      chk("rst_ready",   32'(req_ready), 32'd0);
      chk("rst_busy",    32'(sched_busy), 32'd0);
      chk("rst_err",     32'({err_stall, err_copy}), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // ---- requester 0: three-byte packet
      clear_logs();
      push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
      run_quiet(300, "s1_done");
      chk("s1_nbytes", 32'(n_log), 32'd3);
      chk("s1_b0", 32'(log_data[0]), 32'h11);
      chk("s1_b1", 32'(log_data[1]), 32'h22);
      chk("s1_b2", 32'(log_data[2]), 32'h33);
      chk("s1_ready0", 32'(rr_cnt[0]), 32'd3);
      chk("s1_ngrant", 32'(n_glog), 32'd1);
      chk("s1_owner", 32'(glog[0]), 32'd0);
      chk("s1_grant_end", 32'(grant), 32'd0);
      chk("s1_trans_end", 32'(tx_transaction), 32'd0);

      // ---- round robin from reset: 1 then 2; then 0 and 2 -> 0 first
      do_reset();
      clear_logs();
      push(1, 8'hA1, 1'b1); push(2, 8'hA2, 1'b1);
      run_quiet(300, "s2a_done");
      chk("s2a_first", 32'(glog[0]), 32'd1);
      chk("s2a_second", 32'(glog[1]), 32'd2);
      chk("s2a_b0", 32'(log_data[0]), 32'hA1);
      chk("s2a_b1", 32'(log_data[1]), 32'hA2);
      chk("s2a_b1_src", 32'(log_req[1]), 32'd2);
      clear_logs();
      push(0, 8'hB0, 1'b1); push(2, 8'hB2, 1'b1);
      run_quiet(300, "s2b_done");
      chk("s2b_first", 32'(glog[0]), 32'd0);
      chk("s2b_second", 32'(glog[1]), 32'd2);
      chk("s2b_b0", 32'(log_data[0]), 32'hB0);

      // ---- burst limit: 20 bytes, last flag only on the 20th
      clear_logs();
      for (int k = 0; k < 20; k++) push(3, 8'(8'h40 + k), (k == 19));
      run_quiet(1000, "s3_done");
      c0 = 0; c1 = 0;
      for (int k = 0; k < n_log; k++) begin
         if (log_seq[k] == 0) c0++;
         if (log_seq[k] == 1) c1++;
      end
      chk("s3_nbytes", 32'(n_log), 32'd20);
      chk("s3_ready3", 32'(rr_cnt[3]), 32'd20);
      chk("s3_ngrant", 32'(n_glog), 32'd2);
      chk("s3_regrant", 32'(glog[1]), 32'd3);
      chk("s3_burst1", 32'(c0), 32'd16);
      chk("s3_burst2", 32'(c1), 32'd4);
      chk("s3_b15", 32'(log_data[15]), 32'h4F);
      chk("s3_b16", 32'(log_data[16]), 32'h50);

      // ---- requester stall after one byte
      clear_logs();
      push(1, 8'h5A, 1'b0);
      run_quiet(2000, "s4_done");
      chk("s4_nstall", 32'(n_stall), 32'd1);
      chk("s4_stall_delay", 32'(cyc_stall - cyc_rdy_fall), 32'd1024);
      chk("s4_nbytes", 32'(n_log), 32'd1);
      chk("s4_b0", 32'(log_data[0]), 32'h5A);
      chk("s4_grant_end", 32'(grant), 32'd0);
      chk("s4_trans_end", 32'(tx_transaction), 32'd0);

      // ---- transmitter never copies
      clear_logs();
      copy_en = 1'b0;
      push(2, 8'h77, 1'b1);
      run_quiet(70000, "s5_done");
      copy_en = 1'b1;
      chk("s5_owner", 32'(glog[0]), 32'd2);
      chk("s5_ncopy", 32'(n_copy), 32'd1);
      chk("s5_copy_delay", 32'(cyc_copy - cyc_rdy_rise), 32'd65536);
      chk("s5_nbytes", 32'(n_log), 32'd0);
      chk("s5_rdy_end", 32'(tx_data_ready), 32'd0);
      chk("s5_busy_end", 32'(sched_busy), 32'd0);

      // ---- reset during WAIT_COPY
      clear_logs();
      push(3, 8'h99, 1'b1);
      seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
         @(posedge clk); #2;
         seen = tx_data_ready;
      end
      chk("s6_rdy_seen", 32'(seen), 32'd1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("s6_async_rdy", 32'(tx_data_ready), 32'd0);
      chk("s6_async_trans", 32'(tx_transaction), 32'd0);
      chk("s6_async_grant", 32'(grant), 32'd0);
      repeat (2) @(posedge clk);
      #3;
      clear_queues();
      rst_n = 1'b1;
      clear_logs();
      push(3, 8'hC3, 1'b1); push(0, 8'hC0, 1'b1);
      run_quiet(300, "s6_done");
      chk("s6_first", 32'(glog[0]), 32'd0);
      chk("s6_second", 32'(glog[1]), 32'd3);
      chk("s6_b0", 32'(log_data[0]), 32'hC0);
      chk("s6_b1", 32'(log_data[1]), 32'hC3);

      // ---- protocol invariants accumulated over the whole run
      chk("holdoff_viol", 32'(n_holdoff), 32'd0);
      chk("data_unstable", 32'(n_unstable), 32'd0);
      chk("drain_early", 32'(n_drain_bad), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rs232_tx_scheduler.md
Name: rs232_tx_scheduler

Overview:
- Shares the quick_rs232 transmitter between NUM_REQ byte-stream requesters.
- Grants whole packets to one requester at a time using round-robin priority.
- Sequences the tx_transaction / tx_data_ready / tx_data_copied / tx_busy handshake.
- Enforces a per-grant burst limit, a requester-stall timeout and a transmitter-copy watchdog.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum bytes per grant before forced release (1..255).
- IDLE_TIMEOUT, 1024, clk cycles a granted requester may stall (req_valid low) before the packet is aborted.
- COPY_TIMEOUT, 65536, clk cycles to wait for tx_data_copied before the error path.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester: byte available on its req_data slice.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  per-requester: current byte ends the packet.
- req_ready  out  NUM_REQ  one-cycle pop pulse; the byte was captured.
- grant  out  NUM_REQ  one-hot owner of the transmitter; all zero when idle.
- tx_transaction  out  1  to quick_rs232.
- tx_data  out  8  to quick_rs232.
- tx_data_ready  out  1  to quick_rs232.
- tx_data_copied  in  1  pulse from quick_rs232.
- tx_busy  in  1  from quick_rs232.
- sched_busy  out  1  state != IDLE.
- err_stall  out  1  one-cycle pulse on IDLE_TIMEOUT abort.
- err_copy  out  1  one-cycle pulse on COPY_TIMEOUT.

Behaviour:
- Reset (rst==0, asynchronous):
  - All outputs 0; state IDLE.
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
  - Counters 0.
- IDLE:
  - If any req_valid, pick the first set bit searching from last_grant+1 with wrap-around.
  - Next cycle: grant <= onehot(g), tx_transaction <= 1, byte_cnt <= 0, go to LOAD.
  - No grant change occurs in any other state.
- LOAD:
  - If req_valid[g]: tx_data <= req_data[g], last_r <= req_last[g], req_ready[g] pulses this cycle, tx_data_ready <= 1, copy_cnt <= 0, go to WAIT_COPY.
  - Else: idle_cnt++. When idle_cnt == IDLE_TIMEOUT-1, err_stall pulses and the state goes to DRAIN.
  - idle_cnt clears on every capture.
- WAIT_COPY:
  - tx_data and tx_data_ready are held stable.
  - On tx_data_copied: tx_data_ready <= 0, byte_cnt++.
    - If last_r or byte_cnt+1 == MAX_BURST, go to DRAIN.
    - Else go to LOAD.
    - This gives a minimum 1-cycle gap of tx_data_ready low between bytes.
  - Else copy_cnt++. When copy_cnt == COPY_TIMEOUT-1: err_copy pulses, tx_data_ready <= 0, go to DRAIN.
- DRAIN:
  - Wait for tx_busy==0 sampled for 2 consecutive cycles; this covers the serializer not yet having raised tx_busy after the copy.
  - Then tx_transaction <= 0, grant <= 0, last_grant <= g, go to IDLE.
  - A new grant is therefore possible at the earliest 1 cycle after tx_transaction falls.
- tx_data_copied outside WAIT_COPY is ignored.
- A req_valid drop after capture has no effect.
- Requests from non-granted requesters are held off: req_ready stays 0 for them.
- Burst release with req_last not yet seen:
  - The requester loses the grant; the remainder of its packet is sent in a later grant.
  - This is by design: packet integrity across bursts is the requester's concern.
- Widths:
  - byte_cnt is 8 bits.
  - idle_cnt and copy_cnt are $clog2 of their respective timeout.
  - All counters saturate and never wrap.
- Reset mid-operation: tx_transaction, tx_data_ready and grant drop immediately (asynchronously); the partially sent byte is abandoned.

Decomposition:
- Package rs232_sched_pkg:
  - state encoding: IDLE, LOAD, WAIT_COPY, DRAIN;
  - byte width constant 8;
  - the onehot function.
- Sub-module rs232_rr_arbiter, purely combinational:
  - Inputs: req vector, last_grant.
  - Outputs: one-hot winner and valid.
  - Instantiated once.

Test Plan:
- Requester 0 sends 3 bytes 0x11, 0x22, 0x33 (last on 0x33); bench model pulses tx_data_copied 5 cycles after tx_data_ready -> tx_data sequence 0x11/0x22/0x33, req_ready[0] pulses 3 times, tx_transaction falls after tx_busy low, grant returns to 0.
- Requesters 1 and 2 both valid with single-byte packets 0xA1 and 0xA2 from reset -> grant order 1 then 2; then 0 and 2 both valid -> 0 granted.
- Requester 3 streams 20 bytes with no req_last, MAX_BURST=16 -> exactly 16 req_ready pulses, release; with 3 as the only requester, it is re-granted and sends the remaining 4 bytes.
- Granted requester drops req_valid after 1 byte for 1024 cycles -> err_stall pulses once, tx_transaction falls, grant clears.
- Bench never asserts tx_data_copied -> err_copy after 65536 cycles, tx_data_ready 0, return to IDLE.
- rst asserted low during WAIT_COPY -> tx_data_ready, tx_transaction and grant are 0 in the same timestep; after release, requester 0 has priority.
